// File: rtl/amba_pkg.sv
// Shared AMBA definitions: APB master FSM states, protection bits, counter sizing.
package amba_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } apb_state_t;

  localparam int unsigned PROT_W = 3;

  localparam logic [PROT_W-1:0] PROT_PRIV   = 3'b001;
  localparam logic [PROT_W-1:0] PROT_NONSEC = 3'b010;
  localparam logic [PROT_W-1:0] PROT_INSTR  = 3'b100;

  // Width of a counter able to hold 0..limit; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned limit);
    return (limit < 1) ? 1 : $clog2(limit + 1);
  endfunction

endpackage

// File: rtl/apb_master_if.sv
// Command/response streams plus APB4 bus of the APB master.
interface apb_master_if #(
  parameter int unsigned AWIDTH = 10,
  parameter int unsigned DSIZE  = 2
);
  localparam int unsigned DBYTES = 1 << DSIZE;
  localparam int unsigned DWIDTH = DBYTES * 8;

  // command stream
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [AWIDTH-1:0] req_addr;
  logic [DWIDTH-1:0] req_wdata;
  logic [DBYTES-1:0] req_strb;
  logic [2:0]        req_prot;

  // response stream
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DWIDTH-1:0] rsp_rdata;
  logic              rsp_err;
  logic              rsp_timeout;

  // APB4 bus
  logic              psel;
  logic              penable;
  logic              pwrite;
  logic [AWIDTH-1:0] paddr;
  logic [2:0]        pprot;
  logic [DBYTES-1:0] pstrb;
  logic [DWIDTH-1:0] pwdata;
  logic [DWIDTH-1:0] prdata;
  logic              pready;
  logic              pslverr;

  // View of the APB master itself.
  modport master (
    input  req_valid, req_write, req_addr, req_wdata, req_strb, req_prot,
    output req_ready,
    output rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
    input  rsp_ready,
    output psel, penable, pwrite, paddr, pprot, pstrb, pwdata,
    input  prdata, pready, pslverr
  );

  // View of the surrounding environment (command source, response sink, completer).
  modport slave (
    output req_valid, req_write, req_addr, req_wdata, req_strb, req_prot,
    input  req_ready,
    input  rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
    output rsp_ready,
    input  psel, penable, pwrite, paddr, pprot, pstrb, pwdata,
    output prdata, pready, pslverr
  );

endinterface

// File: rtl/apb_master.sv
// APB4 requester: one command -> one APB transfer -> one response, with optional wait-state timeout.
module apb_master
  import amba_pkg::*;
#(
  parameter int unsigned AWIDTH  = 10,
  parameter int unsigned DSIZE   = 2,
  parameter int unsigned TIMEOUT = 0
) (
  input  logic         pclk,
  input  logic         preset,
  apb_master_if.master bus
);

  localparam int unsigned DBYTES   = 1 << DSIZE;
  localparam int unsigned DWIDTH   = DBYTES * 8;
  localparam int unsigned CW       = cnt_width(TIMEOUT);
  localparam int unsigned CNT_MAX  = (TIMEOUT == 0) ? 1 : TIMEOUT;
  localparam int unsigned CNT_LAST = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;

  apb_state_t        state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;

  logic              psel_q, psel_d;
  logic              penable_q, penable_d;
  logic              pwrite_q, pwrite_d;
  logic [AWIDTH-1:0] paddr_q, paddr_d;
  logic [2:0]        pprot_q, pprot_d;
  logic [DBYTES-1:0] pstrb_q, pstrb_d;
  logic [DWIDTH-1:0] pwdata_q, pwdata_d;

  logic              rsp_valid_q, rsp_valid_d;
  logic [DWIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q, rsp_err_d;
  logic              rsp_timeout_q, rsp_timeout_d;

  // This stalled cycle is the TIMEOUT-th one; a ready completer in the same cycle still wins.
  logic timeout_hit_c;
  assign timeout_hit_c = (TIMEOUT != 0) && !bus.pready && (cnt_q == CW'(CNT_LAST));

  // State and output registers.
  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      psel_q        <= 1'b0;
      penable_q     <= 1'b0;
      pwrite_q      <= 1'b0;
      paddr_q       <= '0;
      pprot_q       <= '0;
      pstrb_q       <= '0;
      pwdata_q      <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_err_q     <= 1'b0;
      rsp_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      psel_q        <= psel_d;
      penable_q     <= penable_d;
      pwrite_q      <= pwrite_d;
      paddr_q       <= paddr_d;
      pprot_q       <= pprot_d;
      pstrb_q       <= pstrb_d;
      pwdata_q      <= pwdata_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_err_q     <= rsp_err_d;
      rsp_timeout_q <= rsp_timeout_d;
    end
  end

  // Next-state selection.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.req_valid) state_d = SETUP;
      SETUP:   state_d = ACCESS;
      ACCESS:  if (bus.pready || timeout_hit_c) state_d = RESP;
      RESP:    if (bus.rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Next values of the registered outputs and the wait-state counter.
  always_comb begin
    cnt_d         = cnt_q;
    psel_d        = psel_q;
    penable_d     = penable_q;
    pwrite_d      = pwrite_q;
    paddr_d       = paddr_q;
    pprot_d       = pprot_q;
    pstrb_d       = pstrb_q;
    pwdata_d      = pwdata_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_err_d     = rsp_err_q;
    rsp_timeout_d = rsp_timeout_q;
    unique case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          psel_d    = 1'b1;
          penable_d = 1'b0;
          pwrite_d  = bus.req_write;
          paddr_d   = bus.req_addr;
          pprot_d   = bus.req_prot;
          pwdata_d  = bus.req_wdata;
          pstrb_d   = bus.req_write ? bus.req_strb : '0;
        end
      end
      SETUP: begin
        penable_d = 1'b1;
        cnt_d     = '0;
      end
      ACCESS: begin
        if (bus.pready) begin
          psel_d        = 1'b0;
          penable_d     = 1'b0;
          rsp_rdata_d   = pwrite_q ? '0 : bus.prdata;
          rsp_err_d     = bus.pslverr;
          rsp_timeout_d = 1'b0;
          rsp_valid_d   = 1'b1;
        end else if (timeout_hit_c) begin
          psel_d        = 1'b0;
          penable_d     = 1'b0;
          rsp_rdata_d   = '0;
          rsp_err_d     = 1'b1;
          rsp_timeout_d = 1'b1;
          rsp_valid_d   = 1'b1;
        end
        if (!bus.pready && (cnt_q != CW'(CNT_MAX))) begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      RESP: begin
        if (bus.rsp_ready) rsp_valid_d = 1'b0;
      end
      default: begin
        psel_d    = 1'b0;
        penable_d = 1'b0;
      end
    endcase
  end

  assign bus.req_ready   = (state_q == IDLE);
  assign bus.psel        = psel_q;
  assign bus.penable     = penable_q;
  assign bus.pwrite      = pwrite_q;
  assign bus.paddr       = paddr_q;
  assign bus.pprot       = pprot_q;
  assign bus.pstrb       = pstrb_q;
  assign bus.pwdata      = pwdata_q;
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_rdata   = rsp_rdata_q;
  assign bus.rsp_err     = rsp_err_q;
  assign bus.rsp_timeout = rsp_timeout_q;

endmodule

// File: tb/tb_apb_master.sv
// Scoreboard bench for apb_master: random commands, APB RAM completer, reference memory model.
module tb_apb_master;
  import amba_pkg::*;

  localparam int unsigned AW = 10;
  localparam int unsigned DS = 2;
  localparam int unsigned TO = 4;
  localparam int unsigned DB = 1 << DS;
  localparam int unsigned DW = DB * 8;

  typedef struct {
    bit            wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DB-1:0] strb;
    logic [2:0]    prot;
    logic [DW-1:0] rdata;
    bit            err;
    bit            tmo;
    int            lat;
  } exp_t;

  typedef struct {
    int wait_n;
    bit err;
  } cpl_t;

  logic clk;
  logic rst;

  apb_master_if #(.AWIDTH(AW), .DSIZE(DS)) bus ();

  apb_master #(.AWIDTH(AW), .DSIZE(DS), .TIMEOUT(TO)) dut (
    .pclk   (clk),
    .preset (rst),
    .bus    (bus)
  );

  int vectors;
  int miscompares;

  exp_t exp_q[$];
  exp_t apb_q[$];
  cpl_t cpl_q[$];

  logic [DW-1:0] ref_mem[int];
  logic [DW-1:0] ram[int];

  int hold;
  int arm;
  int rdy_pct;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got running expected finished");
    $fatal(1);
  end

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] want);
    vectors++;
    if (act !== want) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, want, $time);
    end
  endtask

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] wd,
                                          input logic [DB-1:0] st);
    logic [DW-1:0] r = old;
    for (int b = 0; b < int'(DB); b++) if (st[b]) r[8*b +: 8] = wd[8*b +: 8];
    return r;
  endfunction

  function automatic logic [DW-1:0] ref_rd(input int idx);
    return ref_mem.exists(idx) ? ref_mem[idx] : '0;
  endfunction

  // Issue one command; call at posedge+1. Returns at posedge+1 right after acceptance.
  task automatic issue(input bit wr, input logic [AW-1:0] addr, input logic [DW-1:0] wd,
                       input logic [DB-1:0] st, input logic [2:0] pr, input int wn,
                       input bit er, input bit expect_rsp);
    exp_t e;
    cpl_t c;
    int idx;
    int n;
    idx     = int'(addr >> 2);
    e.wr    = wr;
    e.addr  = addr;
    e.wdata = wd;
    e.strb  = st;
    e.prot  = pr;
    e.tmo   = (wn >= int'(TO));
    e.err   = e.tmo || er;
    e.lat   = e.tmo ? 2 + int'(TO) : 3 + wn;
    e.rdata = (e.tmo || wr) ? '0 : ref_rd(idx);
    if (wr && !e.err) ref_mem[idx] = merge(ref_rd(idx), wd, st);
    c.wait_n = wn;
    c.err    = er;
    cpl_q.push_back(c);
    apb_q.push_back(e);
    if (expect_rsp) exp_q.push_back(e);
    bus.req_valid = 1'b1;
    bus.req_write = wr;
    bus.req_addr  = addr;
    bus.req_wdata = wd;
    bus.req_strb  = st;
    bus.req_prot  = pr;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.req_ready && n < 200);
    if (n >= 200) check("req_accept_budget", 64'(bus.req_ready), 64'd1);
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 1000) begin
      @(posedge clk);
      n++;
    end
    #1;
    if (n >= 1000) check("drain_budget", 64'(exp_q.size()), 64'd0);
    repeat (3) @(posedge clk);
    #1;
  endtask

  // APB RAM completer with per-transfer wait states and error injection.
  initial begin
    cpl_t cur;
    int   wcnt;
    logic [DW-1:0] w;
    cur.wait_n  = 0;
    cur.err     = 1'b0;
    wcnt        = 0;
    bus.pready  = 1'b0;
    bus.pslverr = 1'b0;
    bus.prdata  = '0;
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        bus.pready  = 1'b0;
        bus.pslverr = 1'b0;
      end else if (bus.psel && !bus.penable) begin
        if (cpl_q.size() != 0) cur = cpl_q.pop_front();
        wcnt        = 0;
        bus.pready  = 1'b0;
        bus.pslverr = 1'b0;
      end else if (bus.psel && bus.penable) begin
        if (wcnt < cur.wait_n) begin
          wcnt++;
          bus.pready  = 1'b0;
          bus.pslverr = 1'b0;
          bus.prdata  = DW'($urandom);
        end else begin
          bus.pready  = 1'b1;
          bus.pslverr = cur.err;
          if (bus.pwrite) begin
            bus.prdata = DW'($urandom);
            if (!cur.err) begin
              w = ram.exists(int'(bus.paddr >> 2)) ? ram[int'(bus.paddr >> 2)] : '0;
              for (int b = 0; b < int'(DB); b++)
                if (bus.pstrb[b]) w[8*b +: 8] = bus.pwdata[8*b +: 8];
              ram[int'(bus.paddr >> 2)] = w;
            end
          end else begin
            bus.prdata = ram.exists(int'(bus.paddr >> 2)) ? ram[int'(bus.paddr >> 2)] : '0;
          end
        end
      end else begin
        bus.pready  = 1'b0;
        bus.pslverr = 1'b0;
      end
    end
  end

  // Response sink: random back-pressure, or a forced stall armed by the stimulus.
  initial begin
    bus.rsp_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (arm > 0 && bus.rsp_valid) begin
        hold = arm;
        arm  = 0;
      end
      if (hold > 0) begin
        bus.rsp_ready = 1'b0;
        hold--;
      end else begin
        bus.rsp_ready = ($urandom_range(0, 99) < rdy_pct);
      end
    end
  end

  // Monitor: APB phase/stability checks and response scoreboard.
  initial begin
    int cyc;
    int acc_cyc;
    bit prev_hs;
    bit prev_psel;
    bit rsp_seen;
    bit have_snap;
    logic [63:0] apb_snap;
    logic [63:0] rsp_snap;
    exp_t a;
    cyc = 0; acc_cyc = 0; prev_hs = 0; prev_psel = 0; rsp_seen = 0; have_snap = 0;
    apb_snap = '0; rsp_snap = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        prev_hs = 0; prev_psel = 0; rsp_seen = 0; have_snap = 0;
      end else begin
        if (prev_hs) check("req_ready_after_rsp", 64'(bus.req_ready), 64'd1);
        if (bus.req_valid && bus.req_ready) acc_cyc = cyc;
        if (bus.penable) check("penable_without_psel", 64'(bus.psel), 64'd1);
        if (bus.psel && !bus.penable) begin
          if (apb_q.size() == 0) begin
            check("setup_unexpected", 64'(bus.psel), 64'd0);
          end else begin
            a = apb_q.pop_front();
            check("paddr", 64'(bus.paddr), 64'(a.addr));
            check("pwrite", 64'(bus.pwrite), 64'(a.wr));
            check("pprot", 64'(bus.pprot), 64'(a.prot));
            check("pstrb", 64'(bus.pstrb), a.wr ? 64'(a.strb) : 64'd0);
            if (a.wr) check("pwdata", 64'(bus.pwdata), 64'(a.wdata));
            check("psel_latency", 64'(cyc - acc_cyc), 64'd1);
          end
          apb_snap  = 64'({bus.paddr, bus.pwrite, bus.pstrb, bus.pwdata, bus.pprot});
          have_snap = 1;
        end else if (bus.psel && bus.penable) begin
          check("access_stable", 64'({bus.paddr, bus.pwrite, bus.pstrb, bus.pwdata, bus.pprot}), apb_snap);
          check("penable_after_setup", 64'(prev_psel), 64'd1);
        end else if (have_snap) begin
          check("idle_hold", 64'({bus.paddr, bus.pwrite, bus.pstrb, bus.pwdata, bus.pprot}), apb_snap);
        end
        if (bus.rsp_valid) begin
          check("req_ready_in_resp", 64'(bus.req_ready), 64'd0);
          check("psel_in_resp", 64'(bus.psel), 64'd0);
          if (!rsp_seen) begin
            rsp_seen = 1;
            if (exp_q.size() == 0) begin
              check("rsp_unexpected", 64'(bus.rsp_valid), 64'd0);
            end else begin
              a = exp_q.pop_front();
              check("rsp_rdata", 64'(bus.rsp_rdata), 64'(a.rdata));
              check("rsp_err", 64'(bus.rsp_err), 64'(a.err));
              check("rsp_timeout", 64'(bus.rsp_timeout), 64'(a.tmo));
              check("rsp_latency", 64'(cyc - acc_cyc), 64'(a.lat));
            end
            rsp_snap = 64'({bus.rsp_rdata, bus.rsp_err, bus.rsp_timeout});
          end else begin
            check("rsp_stable", 64'({bus.rsp_rdata, bus.rsp_err, bus.rsp_timeout}), rsp_snap);
          end
        end
        prev_hs = bus.rsp_valid && bus.rsp_ready;
        if (prev_hs) rsp_seen = 0;
        prev_psel = bus.psel;
      end
    end
  end

  // Stimulus: directed scenarios, reset abort, then randomized traffic.
  initial begin
    int wn;
    int r;
    vectors = 0; miscompares = 0;
    hold = 0; arm = 0; rdy_pct = 100;
    rst = 1'b1;
    bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_addr = '0;
    bus.req_wdata = '0; bus.req_strb = '0; bus.req_prot = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_psel", 64'(bus.psel), 64'd0);
    check("rst_penable", 64'(bus.penable), 64'd0);
    check("rst_apb_outs", 64'({bus.paddr, bus.pwrite, bus.pstrb, bus.pwdata, bus.pprot}), 64'd0);
    check("rst_rsp", 64'({bus.rsp_valid, bus.rsp_err, bus.rsp_timeout, bus.rsp_rdata}), 64'd0);
    check("rst_req_ready", 64'(bus.req_ready), 64'd1);
    rst = 1'b0;
    @(posedge clk);
    #1;

    issue(1'b1, AW'('h010), DW'('hDEADBEEF), DB'('hF), PROT_PRIV, 0, 1'b0, 1'b1);
    issue(1'b0, AW'('h010), DW'(0), DB'('hF), PROT_PRIV, 0, 1'b0, 1'b1);
    issue(1'b1, AW'('h020), DW'('h11223344), DB'('hF), 3'b000, 0, 1'b0, 1'b1);
    issue(1'b1, AW'('h020), DW'('h000000AA), DB'('h1), PROT_NONSEC, 0, 1'b0, 1'b1);
    issue(1'b0, AW'('h020), DW'('h55555555), DB'('hF), PROT_INSTR, 0, 1'b0, 1'b1);
    issue(1'b1, AW'('h030), DW'('hCAFEF00D), DB'('hF), 3'b000, 3, 1'b0, 1'b1);
    issue(1'b0, AW'('h030), DW'(0), DB'('h0), 3'b000, 3, 1'b0, 1'b1);
    issue(1'b0, AW'('h010), DW'(0), DB'('h0), 3'b000, 1, 1'b1, 1'b1);
    issue(1'b1, AW'('h040), DW'('h12345678), DB'('hF), 3'b000, 4, 1'b0, 1'b1);
    issue(1'b0, AW'('h040), DW'(0), DB'('h0), 3'b000, 0, 1'b0, 1'b1);
    issue(1'b0, AW'('h030), DW'(0), DB'('h0), 3'b000, 6, 1'b1, 1'b1);
    drain();

    arm = 5;
    issue(1'b0, AW'('h020), DW'(0), DB'('h0), 3'b000, 0, 1'b0, 1'b1);
    drain();

    issue(1'b1, AW'('h050), DW'('hA5A5A5A5), DB'('hF), 3'b000, 20, 1'b0, 1'b0);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("abort_psel", 64'(bus.psel), 64'd0);
    check("abort_penable", 64'(bus.penable), 64'd0);
    check("abort_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    @(posedge clk);
    #2;
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("abort_req_ready", 64'(bus.req_ready), 64'd1);
    repeat (6) @(posedge clk);
    #1;
    check("abort_no_rsp", 64'(bus.rsp_valid), 64'd0);
    issue(1'b0, AW'('h010), DW'(0), DB'('h0), 3'b000, 0, 1'b0, 1'b1);
    drain();

    rdy_pct = 70;
    for (int i = 0; i < 200; i++) begin
      r = int'($urandom_range(0, 9));
      if (r < 6)      wn = 0;
      else if (r < 8) wn = int'($urandom_range(1, 2));
      else            wn = int'($urandom_range(3, 6));
      issue(1'($urandom), AW'($urandom_range(0, 15) * 4), DW'($urandom), DB'($urandom),
            3'($urandom), wn, ($urandom_range(0, 9) == 0), 1'b1);
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
    end
    drain();
    repeat (5) @(posedge clk);
    #1;
    check("cpl_q_empty", 64'(cpl_q.size()), 64'd0);
    check("apb_q_empty", 64'(apb_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
